neighbor_accum_unit: RTL and testbench

NEIGHBOR_ACCUM_UNIT -- requirements
Module: neighbor_accum_unit

---
 rtl/neighbor_accum_unit_pkg.sv | 15 +
 rtl/neighbor_accum_unit_byte_sum4.sv | 11 +
 rtl/neighbor_accum_unit.sv | 122 ++++++++++++
 tb/tb_neighbor_accum_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neighbor_accum_unit_pkg.sv
// Shared EX-stage constants for the neighbour byte-sum accumulator:
// opcode, counter width, last counter value and FSM state encoding.
package neighbor_accum_unit_pkg;

  localparam int unsigned CYCLE_CNT_W = 3;
  localparam logic [4:0] ACCUM_BYTES = 5'b01000;
  localparam logic [CYCLE_CNT_W-1:0] LAST_CYCLE = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/neighbor_accum_unit_byte_sum4.sv
// Combinational sum of the four bytes of a 32-bit word, 10-bit result
// (4 x 255 = 1020 fits without overflow).
module byte_sum4 (
  input  logic [31:0] word_i,
  output logic [9:0]  sum_o
);

  assign sum_o = {2'b00, word_i[7:0]}   + {2'b00, word_i[15:8]} +
                 {2'b00, word_i[23:16]} + {2'b00, word_i[31:24]};

endmodule

// File: rtl/neighbor_accum_unit.sv
// Accumulates the byte sums of four neighbour words (cycleCnt 0..3) and
// pulses resultValid with the total. Define NEIGHBOR_ACCUM_SAT_EN to clamp result at 255.
//
// Handshake: there is no ready; a cycle is consumed only when stall=0 and
// flush=0. resultValid and seqErr are single-cycle pulses with no backpressure.
module neighbor_accum_unit
  import neighbor_accum_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stall,
  input  logic [4:0]             opA,
  input  logic [CYCLE_CNT_W-1:0] cycleCnt,
  input  logic [31:0]            srcData,
  output logic [31:0]            result,
  output logic                   resultValid,
  output logic                   busy,
  output logic                   seqErr,
  output logic [1:0]             state_dbg
);

  state_e                 state_q, state_d;
  logic [11:0]            acc_q, acc_d;
  logic [CYCLE_CNT_W-1:0] exp_cnt_q, exp_cnt_d;
  logic [31:0]            result_q, result_d;
  logic [9:0]             src_sum;
  logic [31:0]            final_val;
  logic                   accept;
  logic                   valid_c;
  logic                   seq_err_c;

  byte_sum4 u_byte_sum4 (
    .word_i (srcData),
    .sum_o  (src_sum)
  );

  assign accept = !stall && !flush;

  always_comb begin
`ifdef NEIGHBOR_ACCUM_SAT_EN
    final_val = (acc_q > 12'd255) ? 32'h0000_00FF : {20'd0, acc_q};
`else
    final_val = {20'd0, acc_q};
`endif
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    exp_cnt_d = exp_cnt_q;
    result_d  = result_q;
    valid_c   = 1'b0;
    seq_err_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          acc_d     = '0;
          exp_cnt_d = '0;
        end else if (accept && opA == ACCUM_BYTES && cycleCnt == '0) begin
          acc_d     = {2'b00, src_sum};
          exp_cnt_d = CYCLE_CNT_W'(1);
          state_d   = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (flush) begin
          acc_d     = '0;
          exp_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (accept) begin
          if (cycleCnt == exp_cnt_q) begin
            acc_d     = acc_q + {2'b00, src_sum};
            exp_cnt_d = exp_cnt_q + CYCLE_CNT_W'(1);
            if (cycleCnt == LAST_CYCLE) state_d = ST_DONE;
          end else begin
            seq_err_c = 1'b1;
            acc_d     = '0;
            exp_cnt_d = '0;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        // Stall is deliberately ignored here; only flush suppresses the pulse.
        acc_d     = '0;
        exp_cnt_d = '0;
        state_d   = ST_IDLE;
        if (!flush) begin
          valid_c  = 1'b1;
          result_d = final_val;
        end
      end
      default: begin
        acc_d     = '0;
        exp_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      exp_cnt_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      exp_cnt_q <= exp_cnt_d;
      result_q  <= result_d;
    end
  end

  assign resultValid = valid_c && !rst;
  assign seqErr      = seq_err_c && !rst;
  assign result      = resultValid ? final_val : result_q;
  assign busy        = (state_q == ST_ACCUM);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_neighbor_accum_unit.sv
// Directed bench for neighbor_accum_unit: transaction-level model checked every
// cycle, plus hand-computed literal expectations per scenario.
module tb_neighbor_accum_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        stall;
  logic [4:0]  opA;
  logic [2:0]  cycleCnt;
  logic [31:0] srcData;
  logic [31:0] result;
  logic        resultValid;
  logic        busy;
  logic        seqErr;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // observed-pulse bookkeeping used by the literal checks
  int          rv_count  = 0;
  int          err_count = 0;
  int          rv_cycle  = 0;
  logic [31:0] rv_value  = '0;

  // transaction-level model: accepted byte sums of the current operation
  int          m_parts[$];
  bit          m_active = 0;
  bit          m_done   = 0;
  logic [31:0] m_last   = '0;

  logic [31:0] exp_res;
  logic        exp_rv;
  logic        exp_err;
  bit          acc_ok;

  localparam logic [4:0] OP_ACC = 5'b01000;

  neighbor_accum_unit dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .stall       (stall),
    .opA         (opA),
    .cycleCnt    (cycleCnt),
    .srcData     (srcData),
    .result      (result),
    .resultValid (resultValid),
    .busy        (busy),
    .seqErr      (seqErr),
    .state_dbg   (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic int byte_total(input logic [31:0] w);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'((w >> (8 * i)) & 32'hFF);
    return s;
  endfunction

  function automatic logic [31:0] model_final();
    int s = 0;
    foreach (m_parts[i]) s += m_parts[i];
`ifdef NEIGHBOR_ACCUM_SAT_EN
    if (s > 255) s = 255;
`endif
    return 32'(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d (0x%08h), expected %0d (0x%08h)",
               name, cyc_n, act, act, exp, exp);
    end
  endtask

  // Compare DUT against the model each cycle, then advance the model.
  always @(negedge clk) begin
    if (cyc_n >= 1) begin
      acc_ok  = !rst && !flush && !stall;
      exp_rv  = m_done && !flush && !rst;
      exp_res = exp_rv ? model_final() : m_last;
      exp_err = m_active && acc_ok && (int'(cycleCnt) != m_parts.size());
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("resultValid", {31'd0, resultValid}, {31'd0, exp_rv});
      check("seqErr", {31'd0, seqErr}, {31'd0, exp_err});
      check("result", result, exp_res);

      if (resultValid === 1'b1) begin
        rv_count++;
        rv_cycle = cyc_n;
        rv_value = result;
      end
      if (seqErr === 1'b1) err_count++;

      if (rst) begin
        m_active = 0; m_done = 0; m_last = '0; m_parts.delete();
      end else if (m_done) begin
        if (!flush) m_last = model_final();
        m_done = 0;
        m_parts.delete();
      end else if (flush) begin
        m_active = 0;
        m_parts.delete();
      end else if (!stall) begin
        if (!m_active) begin
          if (opA == OP_ACC && cycleCnt == 3'd0) begin
            m_active = 1;
            m_parts.delete();
            m_parts.push_back(byte_total(srcData));
          end
        end else if (int'(cycleCnt) == m_parts.size()) begin
          m_parts.push_back(byte_total(srcData));
          if (m_parts.size() == 4) begin
            m_active = 0;
            m_done   = 1;
          end
        end else begin
          m_active = 0;
          m_parts.delete();
        end
      end
    end
  end

  task automatic drive(input logic r, input logic f, input logic s,
                       input logic [4:0] op, input logic [2:0] c, input logic [31:0] d);
    rst = r; flush = f; stall = s; opA = op; cycleCnt = c; srcData = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0);
  endtask

  task automatic full_op(input logic [31:0] d);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'(i), d);
  endtask

  int start_c;
  int rv0;
  int err0;
  logic [31:0] rnd [4];

  initial begin
    drive(1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0);
    idle(1);
    check("reset result", result, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset resultValid", {31'd0, resultValid}, 32'd0);

    // 4 x 0x01010101 -> 16, pulse 4 cycles after the cycleCnt=0 cycle
    start_c = cyc_n;
    rv0 = rv_count;
    full_op(32'h0101_0101);
    idle(2);
    check("basic pulses", 32'(rv_count - rv0), 32'd1);
    check("basic value", rv_value, 32'd16);
    check("basic latency", 32'(rv_cycle - start_c), 32'd4);
    check("basic hold", result, 32'd16);

    // all-ones saturating case
    rv0 = rv_count;
    full_op(32'hFFFF_FFFF);
    idle(2);
    check("ones pulses", 32'(rv_count - rv0), 32'd1);
`ifdef NEIGHBOR_ACCUM_SAT_EN
    check("ones value", rv_value, 32'd255);
`else
    check("ones value", rv_value, 32'd4080);
`endif

    // two stall cycles at cycleCnt=2
    start_c = cyc_n;
    rv0 = rv_count;
    drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd0, 32'h0101_0101);
    drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd1, 32'h0101_0101);
    drive(1'b0, 1'b0, 1'b1, OP_ACC, 3'd2, 32'h0101_0101);
    drive(1'b0, 1'b0, 1'b1, OP_ACC, 3'd2, 32'h0101_0101);
    check("stall busy held", {31'd0, busy}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd2, 32'h0101_0101);
    drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd3, 32'h0101_0101);
    idle(2);
    check("stall value", rv_value, 32'd16);
    check("stall latency", 32'(rv_cycle - start_c), 32'd6);

    // flush at cycleCnt=2, then a fresh op must start from zero
    rv0 = rv_count;
    drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd0, 32'h1111_1111);
    drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd1, 32'h1111_1111);
    drive(1'b0, 1'b1, 1'b0, OP_ACC, 3'd2, 32'h1111_1111);
    check("flush busy drop", {31'd0, busy}, 32'd0);
    idle(2);
    check("flush no pulse", 32'(rv_count - rv0), 32'd0);
    full_op(32'h0202_0202);
    idle(2);
    check("after flush value", rv_value, 32'd32);

    // sequence 0,1,3 -> one seqErr, no result
    rv0 = rv_count;
    err0 = err_count;
    drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd0, 32'h0101_0101);
    drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd1, 32'h0101_0101);
    drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd3, 32'h0101_0101);
    idle(3);
    check("seq err count", 32'(err_count - err0), 32'd1);
    check("seq no pulse", 32'(rv_count - rv0), 32'd0);

    // reset at cycleCnt=1
    rv0 = rv_count;
    drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd0, 32'h0101_0101);
    drive(1'b1, 1'b0, 1'b0, OP_ACC, 3'd1, 32'h0101_0101);
    check("rst result", result, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd2, 32'h0101_0101);
    drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd3, 32'h0101_0101);
    idle(2);
    check("rst no pulse", 32'(rv_count - rv0), 32'd0);

    // IDLE ignores other opcodes and non-zero counters
    drive(1'b0, 1'b0, 1'b0, 5'b00111, 3'd0, 32'h0101_0101);
    drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd1, 32'h0101_0101);
    drive(1'b0, 1'b1, 1'b0, OP_ACC, 3'd0, 32'h0101_0101);
    check("idle ignore busy", {31'd0, busy}, 32'd0);

    // stall in DONE still pulses; flush in DONE suppresses
    rv0 = rv_count;
    full_op(32'h0403_0201);
    drive(1'b0, 1'b0, 1'b1, 5'd0, 3'd0, 32'd0);
    idle(1);
    check("done stall pulses", 32'(rv_count - rv0), 32'd1);
    check("done stall value", rv_value, 32'd40);
    rv0 = rv_count;
    full_op(32'h0505_0505);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 32'd0);
    idle(1);
    check("done flush no pulse", 32'(rv_count - rv0), 32'd0);
    check("done flush hold", result, 32'd40);

    // a few random-data ops checked by the model
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) rnd[i] = $urandom_range(32'hFFFF_FFFF, 0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'(($urandom_range(3, 0) == 0) && i == 2), OP_ACC, 3'(i), rnd[i]);
      drive(1'b0, 1'b0, 1'b0, OP_ACC, 3'd3, rnd[3]);
      idle(2);
    end

    idle(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
